// File: rtl/fir_link_pkg.sv
// Shared types and protocol tokens for the host byte-link loader.
package fir_link_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StSyncAck,
        StCmdWait,
        StCmdAck,
        StCoefLoad,
        StCoefAck,
        StDataLoad,
        StDataAck,
        StRun,
        StDoneAck,
        StErrAck
    } link_state_e;

    typedef enum logic {ModeFull, ModeData} load_mode_e;

    localparam logic [7:0] TokSync     = 8'h39;
    localparam logic [7:0] TokSyncAck  = 8'h46;
    localparam logic [7:0] TokCmdFull  = 8'h68;
    localparam logic [7:0] TokCmdData  = 8'h64;
    localparam logic [7:0] TokCmdAck   = 8'h61;
    localparam logic [7:0] TokCoefDone = 8'h72;
    localparam logic [7:0] TokDataDone = 8'h69;
    localparam logic [7:0] TokFiltDone = 8'h64;
    localparam logic [7:0] TokErr      = 8'h45;

    // Counter width for n states, never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_link_word_asm.sv
// Byte-to-word assembler: collects WORD_W/8 bytes and pulses word_valid_o one cycle later.
module fir_link_word_asm
    import fir_link_pkg::*;
#(
    parameter int unsigned WORD_W    = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        byte_i,
    input  logic              valid_i,
    input  logic              clear_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    localparam int unsigned BYTES = WORD_W / 8;
    localparam int unsigned IW    = addr_w(BYTES);

    logic [IW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              wv_q, wv_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        wv_d   = 1'b0;
        if (clear_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (valid_i) begin
            if (MSB_FIRST) begin
                word_d = (word_q << 8) | WORD_W'(byte_i);
            end else begin
                word_d = (word_q >> 8) | (WORD_W'(byte_i) << (WORD_W - 8));
            end
            if (idx_q == IW'(BYTES - 1)) begin
                idx_d = '0;
                wv_d  = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            word_q <= '0;
            wv_q   <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
            wv_q   <= wv_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = wv_q;

endmodule

// File: rtl/fir_host_link_loader.sv
// Host byte-protocol engine: handshake, coefficient/data buffer loading, filter start and reporting.
module fir_host_link_loader
    import fir_link_pkg::*;
#(
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned NUM_COEF    = 64,
    parameter int unsigned NUM_DATA    = 1024,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 65535,
    localparam int unsigned CAW        = addr_w(NUM_COEF),
    localparam int unsigned DAW        = addr_w(NUM_DATA)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        data_in_i,
    input  logic              rx_valid_i,
    output logic [7:0]        data_out_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              coef_we_o,
    output logic [CAW-1:0]    coef_addr_o,
    output logic              din_we_o,
    output logic [DAW-1:0]    din_addr_o,
    output logic [WORD_W-1:0] wdata_o,
    output logic              start_filter_o,
    input  logic              filter_complete_i,
    output logic              busy_o,
    output logic              error_o
);

    localparam int unsigned TW = addr_w(TIMEOUT_CYC + 1);

    link_state_e    state_q, state_d;
    load_mode_e     mode_q, mode_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_valid_q, tx_valid_d;
    logic [CAW-1:0] coef_addr_q, coef_addr_d;
    logic [DAW-1:0] din_addr_q, din_addr_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           start_q, start_d;
    logic           error_q, error_d;

    logic              in_load, tx_accept, timed_out, word_valid;
    logic [WORD_W-1:0] word;

    assign in_load   = (state_q == StCoefLoad) || (state_q == StDataLoad);
    assign tx_accept = tx_valid_q && tx_ready_i;
    assign timed_out = (TIMEOUT_CYC != 0) && !rx_valid_i && (timer_q + TW'(1) == TW'(TIMEOUT_CYC));

    // Bytes outside the load states never reach the assembler; leaving a load discards any partial.
    fir_link_word_asm #(
        .WORD_W   (WORD_W),
        .MSB_FIRST(MSB_FIRST)
    ) u_word_asm (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .byte_i      (data_in_i),
        .valid_i     (rx_valid_i && in_load),
        .clear_i     (!in_load),
        .word_o      (word),
        .word_valid_o(word_valid)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q && !tx_ready_i;
        coef_addr_d = coef_addr_q;
        din_addr_d  = din_addr_q;
        timer_d     = '0;
        start_d     = 1'b0;
        error_d     = 1'b0;

        unique case (state_q)
            StIdle: if (rx_valid_i && data_in_i == TokSync) state_d = StSyncAck;
            StSyncAck: if (tx_accept) state_d = StCmdWait;
            StCmdWait: begin
                if (rx_valid_i) begin
                    if (data_in_i == TokCmdFull) begin
                        state_d = StCmdAck;
                        mode_d  = ModeFull;
                    end else if (data_in_i == TokCmdData) begin
                        state_d = StCmdAck;
                        mode_d  = ModeData;
                    end else begin
                        state_d = StErrAck;
                    end
                end
            end
            StCmdAck: if (tx_accept) state_d = (mode_q == ModeFull) ? StCoefLoad : StDataLoad;
            StCoefLoad: begin
                if (word_valid) begin
                    if (coef_addr_q == CAW'(NUM_COEF - 1)) state_d = StCoefAck;
                    else coef_addr_d = coef_addr_q + CAW'(1);
                end else if (timed_out) begin
                    state_d = StErrAck;
                end
            end
            StCoefAck: if (tx_accept) state_d = StDataLoad;
            StDataLoad: begin
                if (word_valid) begin
                    if (din_addr_q == DAW'(NUM_DATA - 1)) state_d = StDataAck;
                    else din_addr_d = din_addr_q + DAW'(1);
                end else if (timed_out) begin
                    state_d = StErrAck;
                end
            end
            StDataAck: if (tx_accept) state_d = StRun;
            StRun: if (filter_complete_i) state_d = StDoneAck;
            StDoneAck, StErrAck: if (tx_accept) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (in_load && !rx_valid_i) timer_d = timer_q + TW'(1);

        // Entry actions: load the TX holding register, reset address counters, fire pulses.
        if (state_d != state_q) begin
            case (state_d)
                StSyncAck:  begin tx_valid_d = 1'b1; tx_data_d = TokSyncAck;  end
                StCmdAck:   begin tx_valid_d = 1'b1; tx_data_d = TokCmdAck;   end
                StCoefAck:  begin tx_valid_d = 1'b1; tx_data_d = TokCoefDone; end
                StDataAck:  begin tx_valid_d = 1'b1; tx_data_d = TokDataDone; end
                StDoneAck:  begin tx_valid_d = 1'b1; tx_data_d = TokFiltDone; end
                StErrAck: begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = TokErr;
                    error_d    = 1'b1;
                end
                StCoefLoad: coef_addr_d = '0;
                StDataLoad: din_addr_d = '0;
                StRun:      start_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            mode_q      <= ModeFull;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            coef_addr_q <= '0;
            din_addr_q  <= '0;
            timer_q     <= '0;
            start_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            coef_addr_q <= coef_addr_d;
            din_addr_q  <= din_addr_d;
            timer_q     <= timer_d;
            start_q     <= start_d;
            error_q     <= error_d;
        end
    end

    assign data_out_o     = tx_data_q;
    assign tx_valid_o     = tx_valid_q;
    assign coef_we_o      = (state_q == StCoefLoad) && word_valid;
    assign din_we_o       = (state_q == StDataLoad) && word_valid;
    assign coef_addr_o    = coef_addr_q;
    assign din_addr_o     = din_addr_q;
    assign wdata_o        = word;
    assign start_filter_o = start_q;
    assign error_o        = error_q;
    assign busy_o         = (state_q != StIdle);

endmodule
